// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address type, zero-register index and
// reg2loc select encodings.
package cpu_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t XZR        = 5'd31;
  localparam logic      REG2LOC_RD = 1'b0;
  localparam logic      REG2LOC_RM = 1'b1;

endpackage

// File: rtl/reg_hazard_scoreboard_if.sv
// Decode-stage interface between the instruction decoder (master) and the
// register hazard scoreboard (slave).
interface reg_hazard_scoreboard_if #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int SCNT_W = 16
);
  import cpu_pkg::*;

  logic              reg2loc;
  logic [AW-1:0]     Rn;
  logic [AW-1:0]     Rm;
  logic [AW-1:0]     Rd;
  logic              uses_rn;
  logic              uses_r2;
  logic              issue_valid;
  logic              issue_wr;
  logic              flush;
  logic [AW-1:0]     src2;
  logic              stall;
  logic [NREG-1:0]   busy;
  logic [SCNT_W-1:0] stall_cycles;

  modport master (
    output reg2loc, Rn, Rm, Rd, uses_rn, uses_r2, issue_valid, issue_wr, flush,
    input  src2, stall, busy, stall_cycles
  );

  modport slave (
    input  reg2loc, Rn, Rm, Rd, uses_rn, uses_r2, issue_valid, issue_wr, flush,
    output src2, stall, busy, stall_cycles
  );

endinterface

// File: rtl/reg_hazard_scoreboard_entry.sv
// One scoreboard slot: down-counter of cycles until a pending writeback
// becomes readable. Clear beats load, load beats decrement.
module scoreboard_entry #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic busy
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] count_r;

  // Pending-writeback countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= CW'(LAT);
    end else if (count_r != '0) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign busy = (count_r != '0);

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// Decode-stage RAW interlock: tracks registers with a pending writeback and
// stalls IF/ID while either source read would return stale data.
module reg_hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int LAT    = 3,
  parameter int SCNT_W = 16
) (
  input logic                    clk,
  input logic                    reset,
  reg_hazard_scoreboard_if.slave sb
);

  logic [NREG-1:0]   busy_s;
  logic [NREG-1:0]   load_s;
  logic [AW-1:0]     src2_s;
  logic              haz_n_s;
  logic              haz_2_s;
  logic              stall_s;
  logic              accept_s;
  logic [SCNT_W-1:0] stall_cycles_r;

  // Second read address, same selection as the register-file port
  always_comb begin
    src2_s = sb.Rd;
    if (sb.reg2loc == REG2LOC_RM) begin
      src2_s = sb.Rm;
    end else begin
      src2_s = sb.Rd;
    end
  end

  // Hazard compare uses pre-edge busy state, so a self-dependent write
  // (ADD X1,X1,..) only reloads once its own stall has cleared
  always_comb begin
    haz_n_s  = sb.uses_rn & (sb.Rn != AW'(XZR)) & busy_s[sb.Rn];
    haz_2_s  = sb.uses_r2 & (src2_s != AW'(XZR)) & busy_s[src2_s];
    stall_s  = sb.issue_valid & ~sb.flush & (haz_n_s | haz_2_s);
    accept_s = sb.issue_valid & ~stall_s & ~sb.flush & sb.issue_wr & (sb.Rd != AW'(XZR));
  end

  // One-hot reload of the destination entry
  always_comb begin
    load_s = '0;
    for (int r = 0; r < NREG; r++) begin
      load_s[r] = accept_s & (sb.Rd == AW'(r));
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_entry
    scoreboard_entry #(.LAT(LAT)) u_entry (
      .clk   (clk),
      .reset (reset),
      .load  (load_s[r]),
      .clear (sb.flush),
      .busy  (busy_s[r])
    );
  end

  // Saturating stall statistic; flush leaves it untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_r <= '0;
    end else if (stall_s && (stall_cycles_r != '1)) begin
      stall_cycles_r <= stall_cycles_r + SCNT_W'(1);
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign sb.src2         = src2_s;
  assign sb.stall        = stall_s;
  assign sb.busy         = busy_s;
  assign sb.stall_cycles = stall_cycles_r;

endmodule
